// File: rtl/rc4_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : rc4_pkg
//  Brief   : Shared RC4 controller types and constants (state encoding, sizes).
//  Revision: 1.0
// ============================================================================
package rc4_pkg;

    localparam int MEM_DEPTH     = 256;
    localparam int KEY_BYTES_DEF = 3;

    typedef enum logic [3:0] {
        IDLE   = 4'd0,
        INIT   = 4'd1,
        RD_I   = 4'd2,
        WAIT_I = 4'd3,
        RD_J   = 4'd4,
        WAIT_J = 4'd5,
        WR_I   = 4'd6,
        WR_J   = 4'd7,
        DONE   = 4'd8
    } ksa_state_e;

endpackage
`default_nettype wire

// File: rtl/ksa_swap_ctrl.sv
`default_nettype none
// ============================================================================
//  Module  : ksa_swap_ctrl
//  Brief   : RC4 S-box initialisation and key-scheduling swap controller.
//  Revision: 1.0
// ============================================================================
module ksa_swap_ctrl #(
    parameter int KEY_BYTES = rc4_pkg::KEY_BYTES_DEF,
    parameter int MEM_DEPTH = rc4_pkg::MEM_DEPTH
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [8*KEY_BYTES-1:0] secret_key,
    output logic [7:0]             address,
    output logic [7:0]             data,
    output logic                   wren,
    input  logic [7:0]             q,
    output logic                   busy,
    output logic                   done
);
    import rc4_pkg::*;

    localparam int         KIW      = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;
    localparam logic [7:0] LAST_IDX = 8'(MEM_DEPTH - 1);

    ksa_state_e     state_q, state_d;
    logic [7:0]     i_q, i_d, j_q, j_d;
    logic [7:0]     si_q, si_d, sj_q, sj_d;
    logic [KIW-1:0] k_q, k_d;
    logic           start_q;
    logic [7:0]     key_byte;

    // Start is registered once before IDLE acts on it, which adds the single
    // transition cycle between the sampling edge and the first INIT write.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            i_q     <= '0;
            j_q     <= '0;
            si_q    <= '0;
            sj_q    <= '0;
            k_q     <= '0;
            start_q <= 1'b0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
            si_q    <= si_d;
            sj_q    <= sj_d;
            k_q     <= k_d;
            start_q <= start;
        end
    end

    // Byte 0 of the key is the most significant byte.
    always_comb begin
        key_byte = '0;
        for (int b = 0; b < KEY_BYTES; b++) begin
            if (k_q == KIW'(b)) key_byte = secret_key[8*(KEY_BYTES-1-b) +: 8];
        end
    end

    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        j_d     = j_q;
        si_d    = si_q;
        sj_d    = sj_q;
        k_d     = k_q;
        case (state_q)
            IDLE: begin
                if (start_q) begin
                    state_d = INIT;
                    i_d     = '0;
                    j_d     = '0;
                    k_d     = '0;
                end
            end
            INIT: begin
                if (i_q == LAST_IDX) begin
                    i_d     = '0;
                    state_d = RD_I;
                end else begin
                    i_d = i_q + 8'd1;
                end
            end
            RD_I:   state_d = WAIT_I;
            WAIT_I: begin
                si_d    = q;
                j_d     = j_q + q + key_byte;
                state_d = RD_J;
            end
            RD_J:   state_d = WAIT_J;
            WAIT_J: begin
                sj_d    = q;
                state_d = WR_I;
            end
            WR_I:   state_d = WR_J;
            WR_J: begin
                if (i_q == LAST_IDX) begin
                    state_d = DONE;
                end else begin
                    i_d     = i_q + 8'd1;
                    k_d     = (k_q == KIW'(KEY_BYTES - 1)) ? '0 : k_q + KIW'(1);
                    state_d = RD_I;
                end
            end
            DONE: begin
                if (!start) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        address = '0;
        data    = '0;
        wren    = 1'b0;
        busy    = 1'b1;
        done    = 1'b0;
        case (state_q)
            IDLE:   busy = 1'b0;
            INIT: begin
                address = i_q;
                data    = i_q;
                wren    = 1'b1;
            end
            RD_I, WAIT_I: address = i_q;
            RD_J, WAIT_J: address = j_q;
            WR_I: begin
                address = i_q;
                data    = sj_q;
                wren    = 1'b1;
            end
            WR_J: begin
                address = j_q;
                data    = si_q;
                wren    = 1'b1;
            end
            DONE: begin
                busy = 1'b0;
                done = 1'b1;
            end
            default: busy = 1'b0;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_ksa_swap_ctrl.sv
`default_nettype none
// ============================================================================
//  Module  : tb_ksa_swap_ctrl
//  Brief   : Scoreboard bench for ksa_swap_ctrl against a behavioural S-RAM.
//  Revision: 1.0
// ============================================================================
module tb_ksa_swap_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [23:0] secret_key;
    logic [7:0]  address, data, q;
    logic        wren, busy, done;

    logic [7:0]  mem [256];
    logic [15:0] exp_q [$];
    logic [7:0]  exp_s [256];
    int          checks = 0;
    int          errors = 0;

    ksa_swap_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .secret_key (secret_key),
        .address    (address),
        .data       (data),
        .wren       (wren),
        .q          (q),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (wren) mem[address] <= data;
        q <= mem[address];
    end

    // Monitor: every write the DUT presents must be the next expected one.
    always @(negedge clk) begin
        if (!reset && wren) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: got addr %0h data %0h, none expected", address, data);
            end else begin
                logic [15:0] e;
                e = exp_q.pop_front();
                if ({address, data} !== e) begin
                    errors++;
                    $display("FAIL write_seq: got addr %0h data %0h, expected addr %0h data %0h",
                             address, data, e[15:8], e[7:0]);
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Software KSA: pushes every expected write and records the final S array.
    task automatic build_expected(input logic [23:0] key);
        logic [7:0] s [256];
        logic [7:0] kb [3];
        logic [7:0] j, t;
        kb[0] = key[23:16];
        kb[1] = key[15:8];
        kb[2] = key[7:0];
        for (int i = 0; i < 256; i++) begin
            s[i] = 8'(i);
            exp_q.push_back({8'(i), 8'(i)});
        end
        j = 8'd0;
        for (int i = 0; i < 256; i++) begin
            j = j + s[i] + kb[i % 3];
            exp_q.push_back({8'(i), s[j]});
            exp_q.push_back({j, s[i]});
            t    = s[i];
            s[i] = s[j];
            s[j] = t;
        end
        for (int i = 0; i < 256; i++) exp_s[i] = s[i];
    endtask

    // mode 1: key 00033C hand checks, mode 2: all-zero key hand checks
    task automatic do_run(input logic [23:0] key, input bit toggle, input int mode);
        int  n;
        bit  seen;
        int  bad;
        exp_q.delete();
        build_expected(key);
        secret_key = key;
        start      = 1'b1;
        seen       = 1'b0;
        @(posedge clk);
        for (n = 1; n <= 2000; n++) begin
            @(posedge clk);
            #1;
            if (toggle && n >= 20 && n < 1780 && (n % 37) == 0) start = ~start;
            if (toggle && n == 1780) start = 1'b1;
            if (n == 1) begin
                chk("first_init_wren", wren, 1);
                chk("first_init_addr", address, 0);
                chk("busy_running", busy, 1);
            end
            if (n == 257) begin
                chk("post_init_rd_wren", wren, 0);
                chk("post_init_rd_addr", address, 0);
            end
            if (mode == 2 && (n == 261 || n == 262)) begin
                chk("key0_swap_wren", wren, 1);
                chk("key0_swap_addr", address, 8'h00);
                chk("key0_swap_data", data, 8'h00);
            end
            if (mode == 1 && n == 267) begin
                chk("it1_wri_addr", address, 8'h01);
                chk("it1_wri_data", data, 8'h04);
            end
            if (mode == 1 && n == 268) begin
                chk("it1_wrj_addr", address, 8'h04);
                chk("it1_wrj_data", data, 8'h01);
            end
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got no done within 2000 edges, required edge 1793");
        end else begin
            chk("done_latency", n, 1793);
        end
        chk("busy_at_done", busy, 0);
        chk("all_writes_seen", exp_q.size(), 0);
        bad = 0;
        for (int i = 0; i < 256; i++) if (mem[i] !== exp_s[i]) bad++;
        chk("final_s_array_mismatches", bad, 0);
        chk("s0_key0", (mode == 2) ? {24'd0, mem[0]} : 32'd0, 32'd0);
    endtask

    task automatic release_start();
        start = 1'b0;
        @(posedge clk);
        #1;
        chk("idle_done", done, 0);
        chk("idle_busy", busy, 0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        reset      = 1'b1;
        start      = 1'b0;
        secret_key = 24'h0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_address", address, 0);
        chk("rst_data", data, 0);
        chk("rst_wren", wren, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Init pattern, full schedule and latency with a known key
        do_run(24'h00033C, 1'b0, 1);

        // Start held after completion: done held, no writes
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            chk("hold_done", done, 1);
            chk("hold_busy", busy, 0);
            chk("hold_wren", wren, 0);
        end
        release_start();

        // Reset in the middle of a run
        exp_q.delete();
        build_expected(24'hA5C3E1);
        secret_key = 24'hA5C3E1;
        start      = 1'b1;
        @(posedge clk);
        repeat (500) @(posedge clk);
        #1;
        reset = 1'b1;
        #2;
        chk("midrst_address", address, 0);
        chk("midrst_wren", wren, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        exp_q.delete();
        start = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Restart after reset with the all-zero key (i == j swap)
        do_run(24'h000000, 1'b0, 2);
        release_start();

        // Start toggling while busy must not disturb sequence or latency
        do_run(24'h00033C, 1'b1, 1);
        release_start();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
